// File: rtl/muldiv_unit.sv
// Iterative RV32M execute unit: shift-add multiply and restoring divide on operand magnitudes, sign fixed at the end.
// Result 33 edges after start (1 edge for divide-by-zero, signed overflow or reserved op); start is ignored while busy.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(XLEN);
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t          state_q;
  logic [2:0]      op_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] a_q, hi_q, lo_q, result_q;
  logic            neg_a_q, neg_b_q, special_q, busy_q, done_q;
  logic [4:0]      rd_q, rd_out_q;

  logic            sgn_a, sgn_b, neg_a, neg_b, special;
  logic [XLEN-1:0] mag_a, mag_b, special_res;

  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    case (op)
      4'd0, 4'd1, 4'd4, 4'd6: begin sgn_a = 1'b1; sgn_b = 1'b1; end
      4'd2:                   sgn_a = 1'b1;
      default:                begin end
    endcase
    neg_a = sgn_a & rs1[XLEN-1];
    neg_b = sgn_b & rs2[XLEN-1];
    mag_a = neg_a ? -rs1 : rs1;
    mag_b = neg_b ? -rs2 : rs2;
    // Cases resolved without iterating; the answer is parked in lo_q.
    special     = 1'b0;
    special_res = '0;
    if (op[3]) begin
      special = 1'b1;
    end else if (op[2] && rs2 == '0) begin
      special     = 1'b1;
      special_res = op[1] ? rs1 : '1;
    end else if (op[2] && !op[0] && rs1 == INT_MIN && rs2 == '1) begin
      special     = 1'b1;
      special_res = op[1] ? '0 : INT_MIN;
    end
  end

  logic [XLEN:0]   mul_sum, div_shift;
  logic [XLEN-1:0] div_sub, hi_d, lo_d;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + {1'b0, a_q & {XLEN{lo_q[0]}}};
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_sub   = div_shift[XLEN-1:0] - a_q;
    if (op_q[2]) begin
      if (div_shift >= {1'b0, a_q}) begin
        hi_d = div_sub;
        lo_d = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_d = div_shift[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_d = mul_sum[XLEN:1];
      lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, res_d;

  always_comb begin
    prod_s = (neg_a_q ^ neg_b_q) ? -{hi_q, lo_q} : {hi_q, lo_q};
    quo_s  = (neg_a_q ^ neg_b_q) ? -lo_q : lo_q;
    rem_s  = neg_a_q ? -hi_q : hi_q;
    case (op_q)
      3'd0:             res_d = prod_s[XLEN-1:0];
      3'd1, 3'd2, 3'd3: res_d = prod_s[2*XLEN-1:XLEN];
      3'd4, 3'd5:       res_d = quo_s;
      default:          res_d = rem_s;
    endcase
    if (special_q) res_d = lo_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      cnt_q     <= '0;
      a_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      special_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      rd_q      <= '0;
      rd_out_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
              state_q <= FIN;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          // FIN publishes its result and may accept the next request on the same edge.
          if (state_q == FIN && !flush) begin
            done_q   <= 1'b1;
            result_q <= res_d;
            rd_out_q <= rd_q;
          end
          if (start && !flush) begin
            op_q      <= op[2:0];
            rd_q      <= rd_in;
            neg_a_q   <= neg_a;
            neg_b_q   <= neg_b;
            special_q <= special;
            cnt_q     <= CNT_LOAD;
            hi_q      <= '0;
            a_q       <= op[2] ? mag_b : mag_a;
            lo_q      <= special ? special_res : (op[2] ? mag_a : mag_b);
            state_q   <= special ? FIN : RUN;
            busy_q    <= !special;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed and random M-extension operations against an arithmetic reference model.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [3:0]  op;
  logic [31:0] rs1, rs2;
  logic [4:0]  rd_in;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] prev_res = 32'h0;
  logic [4:0]  prev_rd = 5'h0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .rd_in(rd_in), .flush(flush), .busy(busy), .done(done), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = 64'h0;
    case (o)
      4'd0: begin p = sa * sb; return p[31:0]; end
      4'd1: begin p = sa * sb; return p[63:32]; end
      4'd2: begin p = sa * longint'({32'h0, b}); return p[63:32]; end
      4'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      4'd4: begin
        if (b == 32'h0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        q = sa / sb; p = q; return p[31:0];
      end
      4'd5: return (b == 32'h0) ? 32'hFFFFFFFF : a / b;
      4'd6: begin
        if (b == 32'h0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        q = sa % sb; p = q; return p[31:0];
      end
      4'd7: return (b == 32'h0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit is_special(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o >= 4'd8) return 1'b1;
    if (o >= 4'd4 && b == 32'h0) return 1'b1;
    if ((o == 4'd4 || o == 4'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(5, 0))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(15, 0));
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the unit idle; returns at a negedge with the unit idle again.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit noise, input string tag);
    logic [31:0] exp_res;
    int          lat, got;
    logic        busy_ok;
    exp_res = ref_result(o, a, b);
    lat     = is_special(o, a, b) ? 1 : 33;
    got     = -1;
    busy_ok = 1'b1;
    start = 1'b1; op = o; rs1 = a; rs2 = b; rd_in = rd;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= 40 && got < 0; k++) begin
      if (k > 0) @(negedge clk);
      if (noise && k == 3) begin start = 1'b1; op = 4'd5; rs1 = $urandom; rs2 = $urandom; rd_in = 5'd30; end
      if (noise && k == 8) start = 1'b0;
      if (done) got = k;
      if (lat == 33 && k <= 31 && busy !== 1'b1) busy_ok = 1'b0;
      if ((lat == 1 || k >= 33) && busy !== 1'b0) busy_ok = 1'b0;
    end
    start = 1'b0;
    check({tag, " latency"}, got, lat);
    check({tag, " result"}, result, exp_res);
    check({tag, " rd_out"}, {27'h0, rd_out}, {27'h0, rd});
    check({tag, " busy"}, {31'h0, busy_ok}, 32'h1);
    @(negedge clk);
    check({tag, " done width"}, {31'h0, done}, 32'h0);
    prev_res = exp_res;
    prev_rd  = rd;
  endtask

  initial begin
    logic [31:0] a1, b1, a2, b2, r1, r2;
    logic [3:0]  ro;
    int          d1, d2;
    logic        saw_done;

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 4'h0; rs1 = 32'h0; rs2 = 32'h0; rd_in = 5'h0;
    repeat (2) @(negedge clk);
    check("reset busy", {31'h0, busy}, 32'h0);
    check("reset done", {31'h0, done}, 32'h0);
    check("reset result", result, 32'h0);
    check("reset rd_out", {27'h0, rd_out}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(4'd0, 32'd7, 32'hFFFFFFFD, 5'd5, 1'b0, "MUL 7*-3");
    run_op(4'd1, 32'h80000000, 32'h80000000, 5'd1, 1'b0, "MULH min*min");
    run_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 1'b0, "MULHSU");
    run_op(4'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 1'b0, "MULHU");
    run_op(4'd4, 32'hFFFFFFF9, 32'd2, 5'd4, 1'b0, "DIV -7/2");
    run_op(4'd6, 32'hFFFFFFF9, 32'd2, 5'd6, 1'b0, "REM -7%2");
    run_op(4'd5, 32'd100, 32'd7, 5'd7, 1'b0, "DIVU 100/7");
    run_op(4'd7, 32'd100, 32'd7, 5'd8, 1'b0, "REMU 100%7");
    run_op(4'd5, 32'd5, 32'd0, 5'd9, 1'b0, "DIVU by 0");
    run_op(4'd6, 32'd5, 32'd0, 5'd10, 1'b0, "REM by 0");
    run_op(4'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11, 1'b0, "DIV overflow");
    run_op(4'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12, 1'b0, "REM overflow");
    run_op(4'd9, 32'h1234, 32'h5678, 5'd13, 1'b0, "reserved op");
    run_op(4'd0, 32'h00012345, 32'hFFFF0003, 5'd14, 1'b1, "MUL start ignored");

    // Flush mid-run: no done, previous result and tag remain.
    start = 1'b1; op = 4'd0; rs1 = $urandom; rs2 = $urandom; rd_in = 5'd21;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("flush busy before", {31'h0, busy}, 32'h1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy after", {31'h0, busy}, 32'h0);
    saw_done = 1'b0;
    repeat (40) begin @(negedge clk); if (done) saw_done = 1'b1; end
    check("flush no done", {31'h0, saw_done}, 32'h0);
    check("flush result kept", result, prev_res);
    check("flush rd kept", {27'h0, rd_out}, {27'h0, prev_rd});

    // Back-to-back: start held through FIN, second request taken on the FIN edge.
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    start = 1'b1; op = 4'd0; rs1 = a1; rs2 = b1; rd_in = 5'd3;
    @(negedge clk);
    op = 4'd3; rs1 = a2; rs2 = b2; rd_in = 5'd4;
    d1 = -1; d2 = -1; r1 = 32'h0; r2 = 32'h0;
    for (int k = 1; k <= 80 && d2 < 0; k++) begin
      @(negedge clk);
      if (k == 33) start = 1'b0;
      if (done) begin
        if (d1 < 0) begin d1 = k; r1 = result; end
        else begin d2 = k; r2 = result; end
      end
    end
    start = 1'b0;
    check("b2b first done", d1, 33);
    check("b2b first result", r1, ref_result(4'd0, a1, b1));
    check("b2b second done", d2, 66);
    check("b2b second result", r2, ref_result(4'd3, a2, b2));
    check("b2b second rd", {27'h0, rd_out}, 32'h4);
    @(negedge clk);

    // Asynchronous reset in the middle of a divide.
    start = 1'b1; op = 4'd4; rs1 = $urandom; rs2 = 32'($urandom_range(1000, 1)); rd_in = 5'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid reset busy", {31'h0, busy}, 32'h0);
    check("mid reset done", {31'h0, done}, 32'h0);
    check("mid reset result", result, 32'h0);
    check("mid reset rd_out", {27'h0, rd_out}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin @(negedge clk); if (done) saw_done = 1'b1; end
    check("mid reset no done", {31'h0, saw_done}, 32'h0);
    prev_res = 32'h0;
    prev_rd  = 5'h0;

    for (int i = 0; i < 24; i++) begin
      ro = 4'($urandom_range(7, 0));
      a1 = pick_operand();
      b1 = pick_operand();
      run_op(ro, a1, b1, 5'($urandom_range(31, 0)), (i % 5) == 0, $sformatf("random %0d op %0d", i, ro));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
